dmem_arbiter: RTL

Two-port arbiter that shares the single data memory between the CPU load/store path (port 0) and a debug/loader master (port 1). Uses round-robin arbitration with an optional lock for atomic multi-access sequences. Tracks in-flight reads through a latency pipeline so each read return goes to the requester that issued it. Sits between the requesters and the data memory's write/read ports.

---
 rtl/dmem_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter with optional lock in front of a single data memory.
// Read returns are steered back to the issuing port through a MEM_LAT-deep tag pipeline.
module dmem_arbiter #(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_W    = 16,
  parameter int MEM_LAT   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic                 lock0,
  input  logic                 lock1,
  input  logic [ADDR_W-1:0]    addr0,
  input  logic [ADDR_W-1:0]    addr1,
  input  logic [WORD_SIZE-1:0] wdata0,
  input  logic [WORD_SIZE-1:0] wdata1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 rvalid0,
  output logic                 rvalid1,
  output logic [WORD_SIZE-1:0] rdata,
  output logic                 mem_wen,
  output logic [ADDR_W-1:0]    mem_waddr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  output logic                 mem_ren,
  output logic [ADDR_W-1:0]    mem_raddr,
  input  logic [WORD_SIZE-1:0] mem_rdata
);

  logic               r_rr;
  logic               r_own_v;
  logic               r_own_p;
  logic [MEM_LAT-1:0] r_pv;
  logic [MEM_LAT-1:0] r_pp;

  logic                 w_own_act;
  logic                 w_gnt0;
  logic                 w_gnt1;
  logic                 w_any;
  logic                 w_port;
  logic                 w_we;
  logic                 w_lock;
  logic [ADDR_W-1:0]    w_addr;
  logic [WORD_SIZE-1:0] w_wdata;

  // An owner that drops req releases immediately, so the other port can win this cycle.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_own_act = r_own_v && (r_own_p ? req1 : req0);
    w_gnt0    = 1'b0;
    w_gnt1    = 1'b0;
    if (!rst) begin
      if (w_own_act) begin
        w_gnt0 = !r_own_p;
        w_gnt1 = r_own_p;
      end else if (req0 && req1) begin
        w_gnt0 = !r_rr;
        w_gnt1 = r_rr;
      end else begin
        w_gnt0 = req0;
        w_gnt1 = req1;
      end
    end
    w_any   = w_gnt0 | w_gnt1;
    w_port  = w_gnt1;
    w_we    = w_port ? we1    : we0;
    w_lock  = w_port ? lock1  : lock0;
    w_addr  = w_port ? addr1  : addr0;
    w_wdata = w_port ? wdata1 : wdata0;
  end

  assign gnt0      = w_gnt0;
  assign gnt1      = w_gnt1;
  assign mem_wen   = w_any & w_we;
  assign mem_ren   = w_any & ~w_we;
  assign mem_waddr = w_addr;
  assign mem_raddr = w_addr;
  assign mem_wdata = w_wdata;

  // Grant updates are applied after release so a same-cycle grant decides the final rr/owner.
  // NOTE: sequential state uses non-blocking assignments; later ones in the block take priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr    <= 1'b0;
      r_own_v <= 1'b0;
      r_own_p <= 1'b0;
      r_pv    <= '0;
    end else begin
      if (r_own_v && !w_own_act) begin
        r_own_v <= 1'b0;
        r_rr    <= ~r_own_p;
      end
      if (w_any) begin
        if (w_lock) begin
          r_own_v <= 1'b1;
          r_own_p <= w_port;
        end else begin
          r_own_v <= 1'b0;
          r_rr    <= ~w_port;
        end
      end
      for (int i = MEM_LAT - 1; i > 0; i--) r_pv[i] <= r_pv[i-1];
      r_pv[0] <= w_any & ~w_we;
    end
  end

  // NOTE: port tags are only meaningful alongside their valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    for (int i = MEM_LAT - 1; i > 0; i--) r_pp[i] <= r_pp[i-1];
    r_pp[0] <= w_port;
  end

  assign rvalid0 = r_pv[MEM_LAT-1] & ~r_pp[MEM_LAT-1];
  assign rvalid1 = r_pv[MEM_LAT-1] &  r_pp[MEM_LAT-1];
  assign rdata   = mem_rdata;

endmodule
